// File: rtl/seg7_scroll_display_if.sv
// rtl/seg7_scroll_display_if.sv - digit stream input and display drive bundle for seg7_scroll_display
interface seg7_scroll_display_if;
    logic [3:0]  digit_in;
    logic        digit_valid;
    logic        hold;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  an;
    logic [15:0] digits;
    logic [7:0]  digit_count;

    modport master (
        output digit_in, digit_valid, hold,
        input  seg, dp, an, digits, digit_count
    );

    modport slave (
        input  digit_in, digit_valid, hold,
        output seg, dp, an, digits, digit_count
    );
endinterface

// File: rtl/seg7_scroll_display.sv
// rtl/seg7_scroll_display.sv - right-to-left scrolling 4-digit multiplexed seven-segment driver
module seg7_scroll_display #(
    parameter int REFRESH_DIV = 50000,
    parameter bit ACTIVE_LOW  = 1'b1
) (
    input logic                  clk,
    input logic                  rst,
    seg7_scroll_display_if.slave bus
);
    localparam int       CW      = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [6:0] SEG_INV = {7{ACTIVE_LOW}};
    localparam logic [3:0] AN_INV  = {4{ACTIVE_LOW}};

    logic [15:0]   scroll_q, scroll_d;
    logic [7:0]    count_q, count_d;
    logic [CW-1:0] refresh_q, refresh_d;
    logic [1:0]    idx_q, idx_d;
    logic [6:0]    seg_q, seg_d;
    logic [3:0]    an_q, an_d;
    logic          dp_q, dp_d;

    function automatic logic [6:0] decode(input logic [3:0] code);
        case (code)
            4'h0:    decode = 7'h3F;
            4'h1:    decode = 7'h06;
            4'h2:    decode = 7'h5B;
            4'h3:    decode = 7'h4F;
            4'h4:    decode = 7'h66;
            4'h5:    decode = 7'h6D;
            4'h6:    decode = 7'h7D;
            4'h7:    decode = 7'h07;
            4'h8:    decode = 7'h7F;
            4'h9:    decode = 7'h6F;
            4'hA:    decode = 7'h77;
            4'hB:    decode = 7'h7C;
            4'hC:    decode = 7'h39;
            4'hD:    decode = 7'h5E;
            4'hE:    decode = 7'h79;
            default: decode = 7'h00;
        endcase
    endfunction

    always_comb begin
        scroll_d  = scroll_q;
        count_d   = count_q;
        refresh_d = refresh_q + CW'(1);
        idx_d     = idx_q;

        if (bus.digit_valid && !bus.hold) begin
            scroll_d = {scroll_q[11:0], bus.digit_in};
            if (count_q != 8'hFF) count_d = count_q + 8'd1;
        end

        if (refresh_q == CW'(REFRESH_DIV - 1)) begin
            refresh_d = '0;
            idx_d     = idx_q + 2'd1;
        end

        // an and seg come from the same idx_q so both switch on one edge
        seg_d = SEG_INV ^ decode(scroll_q[{idx_q, 2'b00} +: 4]);
        an_d  = AN_INV ^ (4'b0001 << idx_q);
        dp_d  = ACTIVE_LOW;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            scroll_q  <= 16'hFFFF;
            count_q   <= 8'h00;
            refresh_q <= '0;
            idx_q     <= 2'd0;
            seg_q     <= SEG_INV;
            an_q      <= AN_INV;
            dp_q      <= ACTIVE_LOW;
        end else begin
            scroll_q  <= scroll_d;
            count_q   <= count_d;
            refresh_q <= refresh_d;
            idx_q     <= idx_d;
            seg_q     <= seg_d;
            an_q      <= an_d;
            dp_q      <= dp_d;
        end
    end

    assign bus.seg         = seg_q;
    assign bus.dp          = dp_q;
    assign bus.an          = an_q;
    assign bus.digits      = scroll_q;
    assign bus.digit_count = count_q;
endmodule

// File: tb/tb_seg7_scroll_display.sv
// tb/tb_seg7_scroll_display.sv - directed vector bench for seg7_scroll_display
module tb_seg7_scroll_display;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   passed = 0;

    seg7_scroll_display_if bus ();

    seg7_scroll_display #(.REFRESH_DIV(4), .ACTIVE_LOW(1'b1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        hold;
        logic [3:0]  d;
        logic [15:0] exp_digits;
        logic [7:0]  exp_cnt;
        bit          scan;
    } vec_t;

    vec_t       vecs [10];
    logic [6:0] lut  [16];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s actual=%h required=%h", name, act, exp);
    endtask

    task automatic strobe(input logic [3:0] d, input logic h);
        bus.digit_in    = d;
        bus.hold        = h;
        bus.digit_valid = 1'b1;
        step();
        bus.digit_valid = 1'b0;
        bus.hold        = 1'b0;
    endtask

    // returns once an has just switched to the rightmost digit
    task automatic wait_slot0();
        int n;
        n = 0;
        while (bus.an == 4'hE && n < 64) begin step(); n++; end
        while (bus.an != 4'hE && n < 64) begin step(); n++; end
        if (n >= 64) chk("slot0_timeout", 32'd1, 32'd0);
    endtask

    task automatic scan_check(input logic [15:0] d);
        logic [3:0] nib;
        wait_slot0();
        for (int k = 0; k < 4; k++) begin
            nib = d[4*k +: 4];
            chk($sformatf("scan_an%0d", k), {28'd0, bus.an}, {28'd0, ~(4'b0001 << k)});
            chk($sformatf("scan_seg%0d", k), {25'd0, bus.seg}, {25'd0, ~lut[nib]});
            repeat (4) step();
        end
    endtask

    initial begin
        lut = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h00};
        vecs[0] = '{1'b0, 4'h0, 16'hFFF0, 8'd1, 1'b0};
        vecs[1] = '{1'b0, 4'h2, 16'hFF02, 8'd2, 1'b0};
        vecs[2] = '{1'b0, 4'h1, 16'hF021, 8'd3, 1'b0};
        vecs[3] = '{1'b0, 4'h1, 16'h0211, 8'd4, 1'b1};
        vecs[4] = '{1'b0, 4'h2, 16'h2112, 8'd5, 1'b0};
        vecs[5] = '{1'b0, 4'hF, 16'h112F, 8'd6, 1'b1};
        vecs[6] = '{1'b1, 4'h6, 16'h112F, 8'd6, 1'b0};
        vecs[7] = '{1'b0, 4'h6, 16'h12F6, 8'd7, 1'b1};
        vecs[8] = '{1'b0, 4'h8, 16'h2F68, 8'd8, 1'b0};
        vecs[9] = '{1'b0, 4'h9, 16'hF689, 8'd9, 1'b0};

        bus.digit_in    = 4'h0;
        bus.digit_valid = 1'b0;
        bus.hold        = 1'b0;

        repeat (3) step();
        chk("rst_an", {28'd0, bus.an}, 32'hF);
        chk("rst_seg", {25'd0, bus.seg}, 32'h7F);
        chk("rst_dp", {31'd0, bus.dp}, 32'd1);
        rst = 1'b0;
        step();
        chk("first_an", {28'd0, bus.an}, 32'hE);
        chk("first_seg", {25'd0, bus.seg}, 32'h7F);
        step();
        chk("idle_digits", {16'd0, bus.digits}, 32'hFFFF);
        chk("idle_count", {24'd0, bus.digit_count}, 32'd0);

        for (int i = 0; i < 10; i++) begin
            strobe(vecs[i].d, vecs[i].hold);
            chk($sformatf("vec%0d_digits", i), {16'd0, bus.digits}, {16'd0, vecs[i].exp_digits});
            chk($sformatf("vec%0d_count", i), {24'd0, bus.digit_count}, {24'd0, vecs[i].exp_cnt});
            if (vecs[i].scan) scan_check(vecs[i].exp_digits);
        end

        // mid-slot update reaches seg two cycles after the strobe
        wait_slot0();
        strobe(4'h3, 1'b0);
        chk("lat1_seg", {25'd0, bus.seg}, {25'd0, ~lut[4'h9]});
        step();
        chk("lat2_seg", {25'd0, bus.seg}, {25'd0, ~lut[4'h3]});
        chk("lat2_an", {28'd0, bus.an}, 32'hE);
        chk("lat_digits", {16'd0, bus.digits}, 32'h6893);
        chk("lat_count", {24'd0, bus.digit_count}, 32'd10);

        for (int i = 0; i < 300; i++) strobe(4'h5, 1'b0);
        chk("sat_count", {24'd0, bus.digit_count}, 32'hFF);
        chk("sat_digits", {16'd0, bus.digits}, 32'h5555);
        chk("sat_dp", {31'd0, bus.dp}, 32'd1);

        repeat (2) step();
        rst = 1'b1;
        step();
        chk("mid_rst_digits", {16'd0, bus.digits}, 32'hFFFF);
        chk("mid_rst_count", {24'd0, bus.digit_count}, 32'd0);
        chk("mid_rst_an", {28'd0, bus.an}, 32'hF);
        chk("mid_rst_seg", {25'd0, bus.seg}, 32'h7F);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/seg7_scroll_display.md
Name: seg7_scroll_display

Overview:
- Downstream consumer of the divided-clock digit sequencer.
- Takes its 4-bit digit stream, one digit per valid strobe, and scrolls it right-to-left across a 4-digit multiplexed seven-segment display.
- Decodes 0–9 and A–E to segment patterns; code 4'hF is a blank.
- Runs entirely on the board clock. The upstream slow clock is converted to a one-cycle `digit_valid` strobe before reaching this block.

Parameters:
- REFRESH_DIV, 50000: clk cycles each digit position stays lit before the scan advances; must be ≥ 2.
- ACTIVE_LOW, 1: 1 = `seg`, `dp` and `an` are driven active-low (common-anode board); 0 = active-high.

Ports:
- clk  input  1  board clock; all logic on posedge.
- rst  input  1  synchronous, active-high reset.
- digit_in  input  4  digit code from the upstream sequencer; 4'hF = blank.
- digit_valid  input  1  one-cycle strobe; `digit_in` is sampled when it is high.
- hold  input  1  1 = freeze the scroll buffer; strobes are ignored.
- seg  output  7  segment drive, bit0 = a … bit6 = g.
- dp  output  1  decimal point; always off.
- an  output  4  digit enables, one-hot; an[0] is the rightmost digit.
- digits  output  16  scroll buffer contents; [3:0] = rightmost/newest digit.
- digit_count  output  8  count of accepted digits, saturating.

Behaviour:
- Synchronous reset (rst = 1 at posedge):
  - scroll buffer = 16'hFFFF (all blank).
  - `digit_count` = 0, refresh counter = 0, scan index = 0.
  - `seg` = blank pattern, `dp` = off, `an` = all disabled. With ACTIVE_LOW = 1 this means seg = 7'h7F, dp = 1, an = 4'hF.
  - Reset mid-scroll discards buffer contents immediately.
- Accepting a digit:
  - A digit is accepted when digit_valid = 1 and hold = 0 at a posedge.
  - The buffer shifts: buf <= {buf[11:0], digit_in}.
  - `digits` shows the new value on the following cycle.
  - The oldest digit (buf[15:12]) is discarded.
- Strobe while hold = 1: the buffer and `digit_count` are unchanged. The strobe is lost, not queued.
- Back-to-back strobes on consecutive cycles are each accepted. No minimum spacing is required.
- digit_count:
  - Increments by 1 per accepted digit.
  - Saturates at 8'hFF and does not wrap.
  - Blank codes (4'hF) are counted like any other digit.
- Refresh counter:
  - Counts 0 … REFRESH_DIV-1, then wraps to 0.
  - On the wrap cycle the scan index advances 0→1→2→3→0.
  - `hold` and `digit_valid` do not affect scanning.
- Output register stage:
  - `an` and `seg` are registered together, one cycle after the scan index and buffer. They therefore always change on the same edge, with no ghosting between digits.
  - an (logical) = one-hot(1 << idx).
  - seg (logical) = decode(buf[4*idx+3 : 4*idx]).
  - A buffer update made while a digit is lit appears on `seg` 2 cycles after the strobe, within the current scan slot.
- Decode, logical active-high gfedcba, in hex:
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F
  - A=77, B=7C, C=39, D=5E, E=79, F=00 (blank)
- Polarity: when ACTIVE_LOW = 1, `seg`, `dp` and `an` are the bitwise inverse of the logical values. The logical `dp` is always 0.
- No latches and no combinational outputs. All outputs come from flops.

Test Plan:
1. Assert rst for 3 cycles, release, and hold 2 cycles with ACTIVE_LOW = 1 → digits = 16'hFFFF, digit_count = 0. During reset an = 4'hF and seg = 7'h7F. After release, the first output update has an = 4'hE and seg = 7'h7F (blank).
2. Strobe digits 0, 2, 1, 1 with hold = 0 → digits = 16'h0211 and digit_count = 4. Over one full scan with REFRESH_DIV = 4, the logical seg sequence is 06 (an0), 06 (an1), 5B (an2), 3F (an3), then repeats.
3. Strobe a fifth digit 2 → digits = 16'h2112, with the 0 dropped. Strobe 4'hF → digits = 16'h112F, and the rightmost position shows the blank pattern.
4. Set hold = 1 and strobe 6 → digits and digit_count are unchanged. Release hold and strobe 6 → the last nibble is 6, and the decoded logical seg for that position = 7D.
5. Strobe on 2 consecutive cycles with values 8 then 9 → both are accepted, digits[7:0] = 8'h89, and digit_count increases by 2.
6. Apply 300 strobes → digit_count stops at 8'hFF. Assert rst mid-scan → the next cycle shows digits = FFFF, digit_count = 0, and an disabled.
